// File: rtl/seq_sub_64_pkg.sv
// Shared ALU package for the nibble-serial subtractor: state encoding, slice width
// and the counter-width helper.
package seq_sub_64_pkg;

    localparam int unsigned NIBBLE = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Slice counter width; a single-slice counter still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        int unsigned n_slice;
        n_slice = width / NIBBLE;
        return (n_slice > 1) ? $clog2(n_slice) : 1;
    endfunction

endpackage

// File: rtl/cla_slice_4.sv
// 4-bit carry-lookahead adder slice: sum and carry-out from a, b and carry-in.
module cla_slice_4
    import seq_sub_64_pkg::*;
(
    input  logic [NIBBLE-1:0] i_a,
    input  logic [NIBBLE-1:0] i_b,
    input  logic              i_ci,
    output logic [NIBBLE-1:0] o_sum,
    output logic              o_co
);

    logic [NIBBLE-1:0] w_g;
    logic [NIBBLE-1:0] w_p;
    logic [NIBBLE-1:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // All carries expanded directly from generate/propagate terms.
    assign w_c[0] = i_ci;
    assign w_c[1] = w_g[0] | (w_p[0] & i_ci);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_ci);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_ci);

    assign o_co = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_ci);

    assign o_sum = w_p ^ w_c;

endmodule

// File: rtl/seq_sub_64.sv
// Sequential a-b subtractor: one 4-bit CLA slice reused per cycle, LS nibble first,
// with borrow/zero/sign/overflow flags registered on the final slice.
module seq_sub_64
    import seq_sub_64_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             cf,
    output logic             zf,
    output logic             sf,
    output logic             of
);

    localparam int unsigned NSlice = WIDTH / NIBBLE;
    localparam int unsigned CW     = cnt_width(WIDTH);
    localparam logic [CW-1:0] LastCnt = CW'(NSlice - 1);

    state_e            r_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_nb;
    logic [WIDTH-1:0]  r_diff;
    logic [CW-1:0]     r_cnt;
    logic              r_carry;
    logic              r_zero;
    logic              r_sa;
    logic              r_sb;
    logic              r_busy;
    logic              r_done;
    logic              r_cf;
    logic              r_zf;
    logic              r_sf;
    logic              r_of;

    logic [NIBBLE-1:0] w_sum;
    logic              w_co;

    cla_slice_4 u_slice (
        .i_a   (r_a[NIBBLE-1:0]),
        .i_b   (r_nb[NIBBLE-1:0]),
        .i_ci  (r_carry),
        .o_sum (w_sum),
        .o_co  (w_co)
    );

    // Operands shift right each RUN cycle so the slice always sees bits [3:0];
    // result nibbles shift in from the top and land in place after NSlice cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_a     <= '0;
            r_nb    <= '0;
            r_diff  <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cf    <= 1'b0;
            r_zf    <= 1'b0;
            r_sf    <= 1'b0;
            r_of    <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle, StDone: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_nb    <= ~b;
                        r_sa    <= a[WIDTH-1];
                        r_sb    <= b[WIDTH-1];
                        r_carry <= 1'b1;
                        r_cnt   <= '0;
                        r_zero  <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= StRun;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                StRun: begin
                    r_a     <= r_a >> NIBBLE;
                    r_nb    <= r_nb >> NIBBLE;
                    r_diff  <= {w_sum, r_diff[WIDTH-1:NIBBLE]};
                    r_carry <= w_co;
                    r_zero  <= r_zero & (w_sum == '0);
                    if (r_cnt == LastCnt) begin
                        r_cf    <= ~w_co;
                        r_zf    <= r_zero & (w_sum == '0);
                        r_sf    <= w_sum[NIBBLE-1];
                        r_of    <= (r_sa ^ r_sb) & (r_sa ^ w_sum[NIBBLE-1]);
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign cf   = r_cf;
    assign zf   = r_zf;
    assign sf   = r_sf;
    assign of   = r_of;

endmodule

// File: tb/tb_seq_sub_64.sv
// Self-checking bench for seq_sub_64: scoreboard of expected results checked on done,
// plus per-scenario latency, busy/done and reset checks.
module tb_seq_sub_64;

    localparam int unsigned W = 64;
    localparam int unsigned LAT = W / 4;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         cf;
        logic         zf;
        logic         sf;
        logic         of;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         cf;
    logic         zf;
    logic         sf;
    logic         of;

    int   n_checks;
    int   n_errors;
    exp_t sb[$];

    seq_sub_64 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .cf    (cf),
        .zf    (zf),
        .sf    (sf),
        .of    (of)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb);
        exp_t e;
        e.diff = ta - tb;
        e.cf   = (ta < tb);
        e.zf   = (e.diff == '0);
        e.sf   = e.diff[W-1];
        e.of   = (ta[W-1] != tb[W-1]) && (e.diff[W-1] != ta[W-1]);
        return e;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_done: done=1 with no request outstanding, required done=0");
            end else begin
                e = sb.pop_front();
                if ({diff, cf, zf, sf, of} !== {e.diff, e.cf, e.zf, e.sf, e.of}) begin
                    n_errors++;
                    $display("FAIL result: diff=%h cf=%b zf=%b sf=%b of=%b, required diff=%h cf=%b zf=%b sf=%b of=%b",
                             diff, cf, zf, sf, of, e.diff, e.cf, e.zf, e.sf, e.of);
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input bit expect_result);
        @(posedge clk);
        #1;
        start = 1'b1;
        a     = ta;
        b     = tb;
        if (expect_result) sb.push_back(model(ta, tb));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Returns the number of edges until done, or 0 if it never came.
    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int k = 1; k <= 3 * LAT; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin
                cycles = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, done, diff, cf, zf, sf, of} !== '0) begin
            n_errors++;
            $display("FAIL reset_state: busy=%b done=%b diff=%h flags=%b%b%b%b, required all 0",
                     busy, done, diff, cf, zf, sf, of);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_vectors();
        logic [W-1:0] va[10];
        logic [W-1:0] vb[10];
        int c;
        va[0] = 64'd5;                  vb[0] = 64'd3;
        va[1] = 64'd0;                  vb[1] = 64'd1;
        va[2] = 64'h8000_0000_0000_0000; vb[2] = 64'd1;
        va[3] = 64'h1234;               vb[3] = 64'h1234;
        va[4] = 64'h7FFF_FFFF_FFFF_FFFF; vb[4] = 64'hFFFF_FFFF_FFFF_FFFF;
        va[5] = 64'hFFFF_FFFF_FFFF_FFFF; vb[5] = 64'hFFFF_FFFF_FFFF_FFFF;
        va[6] = 64'h0000_0001_0000_0000; vb[6] = 64'h0000_0000_0000_0001;
        for (int i = 7; i < 10; i++) begin
            va[i] = {$urandom, $urandom};
            vb[i] = {$urandom, $urandom};
        end
        for (int i = 0; i < 10; i++) begin
            send(va[i], vb[i], 1'b1);
            n_checks++;
            if (busy !== 1'b1) begin
                n_errors++;
                $display("FAIL busy_after_start[%0d]: busy=%b, required 1", i, busy);
            end
            wait_done(c);
            n_checks++;
            if (c != LAT || busy !== 1'b0) begin
                n_errors++;
                $display("FAIL latency[%0d]: cycles=%0d busy=%b, required cycles=%0d busy=0",
                         i, c, busy, LAT);
            end
        end
    endtask

    task automatic test_ignore_start();
        @(posedge clk);
        #1;
        start = 1'b1;
        a     = 64'hDEAD_BEEF_0000_1111;
        b     = 64'h0123_4567_89AB_CDEF;
        sb.push_back(model(a, b));
        @(posedge clk);
        for (int i = 1; i <= int'(LAT); i++) begin
            #1;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            @(posedge clk);
        end
        #1;
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL ignore_start_done: done=%b busy=%b, required done=1 busy=0", done, busy);
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL ignore_start_idle: done=%b busy=%b, required done=0 busy=0", done, busy);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        send(64'd1000, 64'd1, 1'b1);
        wait_done(c);
        n_checks++;
        if (c != LAT) begin
            n_errors++;
            $display("FAIL b2b_first_latency: cycles=%0d, required %0d", c, LAT);
        end
        start = 1'b1;
        a     = 64'h0000_0000_0000_0010;
        b     = 64'h0000_0000_0000_0020;
        sb.push_back(model(a, b));
        @(posedge clk);
        #1;
        start = 1'b0;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_reenter: done=%b busy=%b, required done=0 busy=1", done, busy);
        end
        wait_done(c);
        n_checks++;
        if (c != LAT) begin
            n_errors++;
            $display("FAIL b2b_second_latency: cycles=%0d, required %0d", c, LAT);
        end
    endtask

    task automatic test_mid_reset();
        int c;
        int n_done;
        send(64'hFFFF_0000_FFFF_0000, 64'h1111_2222_3333_4444, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, done, diff, cf, zf, sf, of} !== '0) begin
            n_errors++;
            $display("FAIL mid_reset_outputs: busy=%b done=%b diff=%h flags=%b%b%b%b, required all 0",
                     busy, done, diff, cf, zf, sf, of);
        end
        n_done = 0;
        repeat (2 * LAT) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        n_checks++;
        if (n_done != 0) begin
            n_errors++;
            $display("FAIL mid_reset_no_done: done pulses=%0d, required 0", n_done);
        end
        // Reset wins over a simultaneous start.
        @(posedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b1;
        a     = 64'd9;
        b     = 64'd4;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_over_start: busy=%b, required 0", busy);
        end
        send(64'd77, 64'd77, 1'b1);
        wait_done(c);
        n_checks++;
        if (c != LAT) begin
            n_errors++;
            $display("FAIL post_reset_latency: cycles=%0d, required %0d", c, LAT);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_vectors();
        test_ignore_start();
        test_back_to_back();
        test_mid_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drained: outstanding=%0d, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_sub_64.md
SEQ_SUB_64 -- requirements
Module: seq_sub_64

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning operand/result width in bits; legal values are multiples of 4, 8..64.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin a subtraction a-b.
REQ-005 SHALL have port a  input  WIDTH  minuend, sampled only on an accepted start.
REQ-006 SHALL have port b  input  WIDTH  subtrahend, sampled only on an accepted start.
REQ-007 SHALL have port busy  output  1  high while an operation is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking result valid.
REQ-009 SHALL have port diff  output  WIDTH  two's-complement result a-b.
REQ-010 SHALL have port cf  output  1  borrow out (1 when unsigned a < b).
REQ-011 SHALL have port zf  output  1  diff is all zero.
REQ-012 SHALL have port sf  output  1  diff[WIDTH-1].
REQ-013 SHALL have port of  output  1  signed overflow of a-b.

Function
REQ-014 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on accepted start, RUN->DONE after last slice, DONE->IDLE (or RUN on accepted start) after one cycle.
REQ-015 SHALL accept start only when busy=0 (IDLE or DONE); start while busy=1 is ignored with no effect on operands or state.
REQ-016 SHALL on accepted start latch a, ~b into operand registers, set internal carry to 1, clear slice counter, set running-zero flag to 1.
REQ-017 SHALL in RUN process 4 bits per cycle, least-significant nibble first: nibble sum of a-slice, ~b-slice, carry; store to diff nibble; carry <= slice carry-out.
REQ-018 SHALL use a slice counter of width clog2(WIDTH/4) that advances by one per RUN cycle and leaves RUN on terminal count WIDTH/4-1 without wrap side effects.
REQ-019 SHALL give latency WIDTH/4 cycles: start sampled at edge N -> done=1, busy=0 in the cycle after edge N+WIDTH/4 (16 cycles at WIDTH=64).
REQ-020 SHALL register flags at the final slice edge: cf = ~final carry, zf = running-zero AND final nibble==0, sf = diff MSB, of = (a[MSB]^b[MSB]) & (a[MSB]^diff[MSB]).
REQ-021 SHALL hold diff and flags stable from done until the next accepted start; partial diff during RUN is not guaranteed meaningful.
REQ-022 SHALL allow back-to-back: start high during DONE re-enters RUN at next edge, done falls, new operands latched.
REQ-023 SHALL keep busy=1 exactly in RUN; done=1 exactly in DONE.

Reset
REQ-024 SHALL on rst=1 at a clock edge enter IDLE, regardless of state, including mid-RUN; in-flight operation discarded, no done pulse.
REQ-025 SHALL reset outputs: busy=0, done=0, diff=0, cf=0, zf=0, sf=0, of=0; counter and carry cleared.
REQ-026 SHALL give rst priority over start in the same cycle.

Structure
REQ-027 SHALL place state encoding (IDLE/RUN/DONE typedef) and the NIBBLE=4 constant in the shared ALU package.
REQ-028 SHALL instantiate one sub-module, cla_slice_4, a 4-bit carry-lookahead nibble adder (sum, carry-out from a, b, carry-in) reused each cycle.
REQ-029 SHALL contain no combinational path from start, a or b to any output.

Verification
REQ-030 SHALL cover: a=5, b=3 -> after 16 cycles done=1, diff=2, cf=0, zf=0, sf=0, of=0.
REQ-031 SHALL cover: a=0, b=1 -> diff=0xFFFF_FFFF_FFFF_FFFF, cf=1, sf=1, zf=0, of=0.
REQ-032 SHALL cover: a=0x8000_0000_0000_0000, b=1 -> diff=0x7FFF_FFFF_FFFF_FFFF, of=1, sf=0, cf=0; a=b=0x1234 -> diff=0, zf=1.
REQ-033 SHALL cover: start held high with changing a,b during RUN -> result matches first operands only; start in DONE cycle -> second result after 16 more cycles.
REQ-034 SHALL cover: rst asserted at cycle 7 of RUN -> next cycle busy=0, all outputs 0, no done pulse; fresh start then completes correctly.
